// File: rtl/noc_pkg.sv
// noc_pkg: shared tree-NoC packet width, address field bounds and node FSM states
package noc_pkg;
  localparam int W = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;
  typedef enum logic [1:0] {IDLE, SEL, DATA} state_t;
endpackage

// File: rtl/arbiter2_merge_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant
// Ports: req[1:0] requests, last = previous winner, grant[1:0] one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  // On a tie the port that did not win last time takes the grant.
  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/arbiter2_merge.sv
// arbiter2_merge: round-robin merge of two child channels, announces winner on S then forwards packet on Out
// Ports: CLK/_RESET (async active-low); in0_*/in1_* child valid/ready channels;
//        s_* winning-port token channel; out_* forwarded-packet channel.
module arbiter2_merge
  import noc_pkg::*;
(
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  state_t state, state_nx;
  logic armed, last, win, acc;
  logic [W-1:0] pkt;
  logic [1:0] grant;
  rr_arb2 u_arb (.req({in1_valid, in0_valid}), .last, .grant);
  assign s_data = win;
  assign out_data = pkt;
  // armed keeps both readies low while in reset and until the first clock edge after release.
  always_comb begin
    state_nx = state;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    s_valid = 1'b0;
    out_valid = 1'b0;
    acc = 1'b0;
    case (state)
      IDLE: begin
        in0_ready = armed & grant[0];
        in1_ready = armed & grant[1];
        acc = in0_ready | in1_ready;
        state_nx = acc ? SEL : IDLE;
      end
      SEL: begin
        s_valid = 1'b1;
        state_nx = s_ready ? DATA : SEL;
      end
      DATA: begin
        out_valid = 1'b1;
        state_nx = out_ready ? IDLE : DATA;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state <= IDLE;
      armed <= 1'b0;
      last <= 1'b1;
      win <= 1'b0;
      pkt <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (acc) begin
        win <= grant[1];
        last <= grant[1];
        pkt <= grant[1] ? in1_data : in0_data;
      end
    end
  end
endmodule

// File: tb/tb_arbiter2_merge.sv
// tb_arbiter2_merge: directed self-checking bench for arbiter2_merge
module tb_arbiter2_merge;
  logic CLK = 1'b0;
  logic _RESET = 1'b0;
  logic [8:0] in0_data = '0, in1_data = '0, out_data;
  logic in0_valid = 1'b0, in1_valid = 1'b0, in0_ready, in1_ready;
  logic s_data, s_valid, s_ready = 1'b0;
  logic out_valid, out_ready = 1'b0;
  int total = 0, bad = 0;
  arbiter2_merge dut (
    .CLK(CLK), ._RESET(_RESET),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset;
    _RESET = 1'b0;
    #2;
    _RESET = 1'b1;
    step;
  endtask
  initial begin
    in0_valid = 1'b1;
    in0_data = 9'h1A5;
    s_ready = 1'b1;
    out_ready = 1'b1;
    #2;
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_out_data", out_data, 0);
    _RESET = 1'b1;
    #1;
    chk("pre_edge_in0_ready", in0_ready, 0);
    step;
    chk("t1_in0_ready", in0_ready, 1);
    chk("t1_in1_ready", in1_ready, 0);
    step;
    in0_valid = 1'b0;
    chk("t1_s_valid", s_valid, 1);
    chk("t1_s_data", s_data, 0);
    chk("t1_out_valid_sel", out_valid, 0);
    step;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 9'h1A5);
    chk("t1_s_valid_data", s_valid, 0);
    step;
    chk("t1_idle_out_valid", out_valid, 0);
    do_reset;
    in0_data = 9'h011;
    in1_data = 9'h022;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_in0_ready", in0_ready, (k % 2 == 0) ? 1 : 0);
      chk("t2_in1_ready", in1_ready, (k % 2 == 1) ? 1 : 0);
      step;
      chk("t2_s_data", s_data, k % 2);
      step;
      chk("t2_out_data", out_data, (k % 2 == 1) ? 9'h022 : 9'h011);
      step;
    end
    in0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in1_data = 9'h100 + 9'(k);
      #1;
      chk("t3_in1_ready", in1_ready, 1);
      step;
      chk("t3_s_data", s_data, 1);
      step;
      chk("t3_out_data", out_data, 9'h100 + 9'(k));
      step;
    end
    in0_valid = 1'b1;
    in0_data = 9'h0AA;
    #1;
    chk("t3_tie_in0_ready", in0_ready, 1);
    chk("t3_tie_in1_ready", in1_ready, 0);
    step;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    chk("t3_tie_s_data", s_data, 0);
    step;
    chk("t3_tie_out_data", out_data, 9'h0AA);
    step;
    in0_valid = 1'b1;
    in0_data = 9'h055;
    s_ready = 1'b0;
    step;
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data = 9'h0CC;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_s_valid", s_valid, 1);
      chk("t4_s_data", s_data, 0);
      chk("t4_in1_ready", in1_ready, 0);
      chk("t4_out_valid", out_valid, 0);
      step;
    end
    s_ready = 1'b1;
    step;
    chk("t4_out_valid_after", out_valid, 1);
    chk("t4_out_data", out_data, 9'h055);
    step;
    chk("t4_late_in1_ready", in1_ready, 1);
    step;
    in1_valid = 1'b0;
    chk("t4_late_s_data", s_data, 1);
    step;
    chk("t4_late_out_data", out_data, 9'h0CC);
    step;
    in0_valid = 1'b1;
    in0_data = 9'h0F0;
    out_ready = 1'b0;
    step;
    in0_data = 9'h0F1;
    step;
    for (int i = 0; i < 4; i++) begin
      chk("t5_out_valid", out_valid, 1);
      chk("t5_out_data", out_data, 9'h0F0);
      chk("t5_in0_ready", in0_ready, 0);
      step;
    end
    out_ready = 1'b1;
    step;
    chk("t5_idle_in0_ready", in0_ready, 1);
    step;
    in0_valid = 1'b0;
    chk("t5_s_data", s_data, 0);
    step;
    chk("t5_out_data_new", out_data, 9'h0F1);
    step;
    in1_valid = 1'b1;
    in1_data = 9'h1EE;
    out_ready = 1'b0;
    step;
    in1_valid = 1'b0;
    step;
    chk("t6_out_valid_pre", out_valid, 1);
    chk("t6_out_data_pre", out_data, 9'h1EE);
    _RESET = 1'b0;
    in0_valid = 1'b1;
    in0_data = 9'h033;
    in1_valid = 1'b1;
    in1_data = 9'h044;
    out_ready = 1'b1;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_s_valid", s_valid, 0);
    chk("t6_rst_in0_ready", in0_ready, 0);
    #1;
    _RESET = 1'b1;
    step;
    chk("t6_tie_in0_ready", in0_ready, 1);
    chk("t6_tie_in1_ready", in1_ready, 0);
    step;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    chk("t6_s_data", s_data, 0);
    step;
    chk("t6_out_data", out_data, 9'h033);
    step;
    chk("t6_idle_out_valid", out_valid, 0);
    chk("t6_idle_s_valid", s_valid, 0);
    step;
    chk("t6_no_resend", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbiter2_merge.md
# arbiter2_merge

Two-input merge stage for the tree NoC: accepts 9-bit packets from two child channels (In0, In1), selects one per transaction with round-robin fairness, reports the winning port on a 1-bit S channel, then forwards the packet unchanged on Out. It is the upward-path counterpart of the 2-way decoder node and feeds a decoder node or parent merge. The clocked RTL body uses valid/ready channels; the existing 1-of-N SEND/RECV wrappers adapt it to the asynchronous channels.

## Interface
- W, 9, packet width; bits [8:5] carry the destination address, untouched here
- CLK  in  1  clock
- _RESET  in  1  reset, asynchronous, active-low
- in0_data  in  W  packet from child 0
- in0_valid  in  1  child 0 offers a packet
- in0_ready  out  1  child 0 packet accepted this cycle when in0_valid is also high
- in1_data / in1_valid / in1_ready  same as in0_* for child 1
- s_data  out  1  winning port index (0 = In0, 1 = In1)
- s_valid  out  1  S token offered
- s_ready  in  1  S token consumed
- out_data  out  W  forwarded packet
- out_valid  out  1  packet offered
- out_ready  in  1  packet consumed

## Operation
- FSM states: IDLE, SEL, DATA.
- IDLE: winner computed combinationally. Both valid -> port != last; one valid -> that port; none -> no grant. The winner's in*_ready = 1; the loser's ready = 0. On handshake: latch data into pkt, latch the winner into win, set last = win, and go to SEL.
- SEL: s_valid = 1, s_data = win. On s_ready, go to DATA.
- DATA: out_valid = 1, out_data = pkt. On out_ready, go to IDLE.
- Ready outputs are 0 outside IDLE; a losing or late input waits with its valid held.
- Upstream rule: in*_valid and in*_data stay stable until accepted. The block does not check this.
- No modification, reordering or dropping of packets except on reset.

## Timing
- Reset state: IDLE, last = 1 so In0 wins the first tie, pkt = 0, win = 0.
- Reset output values: all readies 0 until the first clock edge evaluates IDLE; s_valid, out_valid, s_data and out_data all 0.
- Accept at edge N. Then s_valid rises at N+1.
- If s_ready is high at N+1, out_valid rises at N+2.
- If out_ready is high at N+2, the block is back in IDLE at N+3.
- Peak throughput: 1 packet per 3 cycles.
- Back-pressure: s_valid/s_data or out_valid/out_data held constant until the matching ready.
- Simultaneous in0_valid & in1_valid: exactly one ready asserted, chosen per round-robin.
- A valid arriving in SEL/DATA is not accepted until the next IDLE cycle.
- Reset mid-operation: the in-flight packet is discarded and no partial S/Out token remains.

## Structure
- Package noc_pkg holds W, the ADDR field bounds [8:5], and the state enum {IDLE, SEL, DATA}; shared with the decoder node.
- Sub-module rr_arb2: inputs req[1:0] and last; outputs grant[1:0] (one-hot or zero). Purely combinational. The top module owns last and the FSM.

## Test plan
- Reset, then in0 = 9'h1A5 alone: in0_ready at the first IDLE cycle, then s_data = 0, then out_data = 9'h1A5. 3 cycles total with readies tied high.
- Both valid from reset (in0 = 9'h011, in1 = 9'h022) with both held: S sequence 0,1,0,1 and Out sequence 011,022,011,022. Strict alternation.
- in1-only stream of 4 packets: all accepted, S always 1, then in0 tie resolves to 0 (last = 1).
- s_ready low 5 cycles then high: s_valid/s_data stable, no in*_ready, out_valid stays 0 until after the S handshake.
- out_ready low 4 cycles in DATA: out_data stable, new in0_valid not accepted until IDLE.
- Assert _RESET during DATA: out_valid drops to 0 immediately. After release, tie resolves to In0 and the discarded packet is not re-sent.
